// File: rtl/jtag_tap_pkg.sv
// Shared types, default opcodes and the TAP next-state function for the JTAG TAP controller.
package jtag_tap_pkg;

  localparam int unsigned DEF_IRW       = 6;
  localparam logic [5:0]  DEF_USER_OP   = 6'h02;
  localparam logic [5:0]  DEF_IDCODE_OP = 6'h09;
  localparam logic [5:0]  BYPASS_OP     = 6'h3F;
  localparam logic [31:0] DEF_IDCODE    = 32'h0362D093;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_t;

  // IEEE 1149.1 state graph on TMS.
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = s;
    case (s)
      TLR:    n = tms ? TLR    : RTI;
      RTI:    n = tms ? SEL_DR : RTI;
      SEL_DR: n = tms ? SEL_IR : CAP_DR;
      CAP_DR: n = tms ? EX1_DR : SH_DR;
      SH_DR:  n = tms ? EX1_DR : SH_DR;
      EX1_DR: n = tms ? UPD_DR : PAU_DR;
      PAU_DR: n = tms ? EX2_DR : PAU_DR;
      EX2_DR: n = tms ? UPD_DR : SH_DR;
      UPD_DR: n = tms ? SEL_DR : RTI;
      SEL_IR: n = tms ? TLR    : CAP_IR;
      CAP_IR: n = tms ? EX1_IR : SH_IR;
      SH_IR:  n = tms ? EX1_IR : SH_IR;
      EX1_IR: n = tms ? UPD_IR : PAU_IR;
      PAU_IR: n = tms ? EX2_IR : PAU_IR;
      EX2_IR: n = tms ? UPD_IR : SH_IR;
      UPD_IR: n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register and next-state logic only.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       TCK,
  input  logic       RESET,
  input  logic       TMS,
  output tap_state_t state_o
);

  tap_state_t state_q;
  tap_state_t state_d;

  always_ff @(posedge TCK) begin
    if (RESET) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    state_d = tap_next(state_q, TMS);
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with IR, IDCODE and BYPASS registers and BSCANE2-style strobes.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter int unsigned       IRW       = DEF_IRW,
  parameter logic [IRW-1:0]    USER_OP   = IRW'(DEF_USER_OP),
  parameter logic [IRW-1:0]    IDCODE_OP = IRW'(DEF_IDCODE_OP),
  parameter logic [31:0]       IDCODE    = DEF_IDCODE
) (
  input  logic           TCK,
  input  logic           RESET,
  input  logic           TMS,
  input  logic           TDI,
  input  logic           TDO_USER,
  output logic           TDO,
  output logic           TDO_EN,
  output logic           CAPTURE,
  output logic           SHIFT,
  output logic           UPDATE,
  output logic           SEL,
  output logic           RUNTEST,
  output logic           TAP_RESET,
  output logic [IRW-1:0] IR_OUT
);

  tap_state_t state;
  tap_state_t state_nx;

  logic [IRW-1:0] ir_q, ir_d;
  logic [IRW-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]    id_q, id_d;
  logic           byp_q, byp_d;
  logic           is_sel;
  logic           is_idcode;

  jtag_tap_fsm u_fsm (
    .TCK     (TCK),
    .RESET   (RESET),
    .TMS     (TMS),
    .state_o (state)
  );

  // Lookahead so the active IR already reads IDCODE_OP on the first TLR cycle.
  assign state_nx  = tap_next(state, TMS);
  assign is_sel    = (ir_q == USER_OP);
  assign is_idcode = (ir_q == IDCODE_OP);

  always_comb begin
    ir_d    = ir_q;
    ir_sr_d = ir_sr_q;
    id_d    = id_q;
    byp_d   = byp_q;
    case (state)
      CAP_IR: ir_sr_d = IRW'(1);
      SH_IR:  ir_sr_d = {TDI, ir_sr_q[IRW-1:1]};
      UPD_IR: ir_d    = ir_sr_q;
      CAP_DR: begin
        byp_d = 1'b0;
        if (is_idcode) id_d = IDCODE;
      end
      SH_DR: begin
        byp_d = TDI;
        if (is_idcode) id_d = {TDI, id_q[31:1]};
      end
      default: ;
    endcase
    if (state_nx == TLR) ir_d = IDCODE_OP;
  end

  always_ff @(posedge TCK) begin
    if (RESET) begin
      ir_q    <= IDCODE_OP;
      ir_sr_q <= IDCODE_OP;
      id_q    <= IDCODE;
      byp_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
      id_q    <= id_d;
      byp_q   <= byp_d;
    end
  end

  // Serial output mux; the user chain takes priority in Shift-DR.
  always_comb begin
    TDO = 1'b0;
    if (state == SH_IR) begin
      TDO = ir_sr_q[0];
    end else if (state == SH_DR) begin
      if (is_sel)         TDO = TDO_USER;
      else if (is_idcode) TDO = id_q[0];
      else                TDO = byp_q;
    end
  end

  assign TDO_EN    = (state == SH_IR) || (state == SH_DR);
  assign CAPTURE   = (state == CAP_DR);
  assign SHIFT     = (state == SH_DR);
  assign UPDATE    = (state == UPD_DR);
  assign RUNTEST   = (state == RTI);
  assign TAP_RESET = (state == TLR);
  assign SEL       = is_sel;
  assign IR_OUT    = ir_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IDCODE scan, IR loads, user-chain scan, bypass, abort paths.
module tb_jtag_tap_ctrl;

  logic       TCK;
  logic       RESET;
  logic       TMS;
  logic       TDI;
  logic       TDO_USER;
  logic       TDO;
  logic       TDO_EN;
  logic       CAPTURE;
  logic       SHIFT;
  logic       UPDATE;
  logic       SEL;
  logic       RUNTEST;
  logic       TAP_RESET;
  logic [5:0] IR_OUT;

  int   n_checks;
  int   n_errors;
  int   cap_cnt;
  int   sh_cnt;
  int   upd_cnt;
  logic tdo_s;
  logic tdo_user_v;

  jtag_tap_ctrl dut (
    .TCK       (TCK),
    .RESET     (RESET),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO_USER  (TDO_USER),
    .TDO       (TDO),
    .TDO_EN    (TDO_EN),
    .CAPTURE   (CAPTURE),
    .SHIFT     (SHIFT),
    .UPDATE    (UPDATE),
    .SEL       (SEL),
    .RUNTEST   (RUNTEST),
    .TAP_RESET (TAP_RESET),
    .IR_OUT    (IR_OUT)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One TCK cycle: drive at negedge, sample pre-edge outputs, then advance past the posedge.
  task automatic step(input logic tms, input logic tdi);
    @(negedge TCK);
    TMS      = tms;
    TDI      = tdi;
    TDO_USER = tdo_user_v;
    #1;
    tdo_s = TDO;
    if (CAPTURE) cap_cnt++;
    if (SHIFT)   sh_cnt++;
    if (UPDATE)  upd_cnt++;
    @(posedge TCK);
    #1;
  endtask

  // From RTI: load an instruction and return to RTI, checking the captured IR pattern.
  task automatic load_ir(input logic [5:0] op);
    logic [5:0] cap;
    cap = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("ir_tdo_en", 64'(TDO_EN), 64'd1);
    for (int i = 0; i < 6; i++) begin
      step(i == 5, op[i]);
      cap[i] = tdo_s;
    end
    check("ir_capture", 64'(cap), 64'h01);
    step(1'b1, 1'b0);
    check("ir_before_upd", 64'(IR_OUT), 64'(op == 6'h09 ? 6'h09 : IR_OUT));
    step(1'b0, 1'b0);
    check("ir_loaded", 64'(IR_OUT), 64'(op));
  endtask

  initial begin
    logic [31:0] idw;
    logic [3:0]  bp_in;
    logic [3:0]  bp_out;
    n_checks   = 0;
    n_errors   = 0;
    cap_cnt    = 0;
    sh_cnt     = 0;
    upd_cnt    = 0;
    tdo_user_v = 1'b0;
    RESET      = 1'b1;
    TMS        = 1'b0;
    TDI        = 1'b0;
    TDO_USER   = 1'b0;

    // Reset state
    step(1'b0, 1'b0);
    RESET = 1'b0;
    check("rst_tap_reset", 64'(TAP_RESET), 64'd1);
    check("rst_strobes",   64'({CAPTURE, SHIFT, UPDATE, RUNTEST, TDO_EN, TDO}), 64'd0);
    check("rst_sel",       64'(SEL), 64'd0);
    check("rst_ir",        64'(IR_OUT), 64'h09);
    step(1'b0, 1'b0);
    check("rti_tap_reset", 64'(TAP_RESET), 64'd0);
    check("rti_runtest",   64'(RUNTEST), 64'd1);
    check("rti_ir",        64'(IR_OUT), 64'h09);

    // 32-bit IDCODE scan
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("id_capture", 64'(CAPTURE), 64'd1);
    step(1'b0, 1'b0);
    check("id_shift", 64'(SHIFT), 64'd1);
    idw = '0;
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'b0);
      idw[i] = tdo_s;
    end
    check("idcode", 64'(idw), 64'h0362D093);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Select user chain
    load_ir(6'h02);
    check("sel_user", 64'(SEL), 64'd1);

    // 64-bit user scan
    cap_cnt = 0;
    sh_cnt  = 0;
    upd_cnt = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      tdo_user_v = ((i % 3) == 0);
      step(i == 63, 1'b1);
      check("user_tdo", 64'(tdo_s), 64'(tdo_user_v));
    end
    tdo_user_v = 1'b0;
    step(1'b1, 1'b0);
    check("user_update", 64'(UPDATE), 64'd1);
    step(1'b0, 1'b0);
    check("user_cap_cnt", 64'(cap_cnt), 64'd1);
    check("user_sh_cnt",  64'(sh_cnt), 64'd64);
    check("user_upd_cnt", 64'(upd_cnt), 64'd1);
    check("user_sel",     64'(SEL), 64'd1);

    // Bypass: one-bit delay
    load_ir(6'h3F);
    check("byp_sel", 64'(SEL), 64'd0);
    bp_in  = 4'b1101;
    bp_out = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, bp_in[i]);
      bp_out[i] = tdo_s;
    end
    check("bypass", 64'(bp_out), 64'(4'b1010));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Reset mid-scan
    upd_cnt = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    RESET = 1'b1;
    step(1'b0, 1'b0);
    RESET = 1'b0;
    check("midrst_tlr", 64'(TAP_RESET), 64'd1);
    check("midrst_ir",  64'(IR_OUT), 64'h09);
    check("midrst_upd", 64'(upd_cnt), 64'd0);
    check("midrst_upd_now", 64'(UPDATE), 64'd0);

    // Five TMS=1 edges from PAU_IR
    step(1'b0, 1'b0);
    load_ir(6'h02);
    upd_cnt = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("pau_shift", 64'({SHIFT, TDO_EN}), 64'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms5_tlr", 64'(TAP_RESET), 64'd1);
    check("tms5_ir",  64'(IR_OUT), 64'h09);
    check("tms5_sel", 64'(SEL), 64'd0);
    check("tms5_upd", 64'(upd_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
